// File: rtl/bf_pkg.sv
// Shared types and helpers for the brainfuck core's UART transmit and program-load receive paths.
package bf_pkg;

  typedef logic [7:0] bf_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bf_uart_tx_if.sv
// Byte stream valid/ready handshake from the core's '.' instruction into the UART transmitter.
interface bf_uart_tx_if;
  import bf_pkg::*;

  bf_byte_t in_data;
  logic     in_valid;
  logic     in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/bf_byte_fifo.sv
// Single-clock byte FIFO with occupancy count; shared by the transmit and receive UART paths.
module bf_byte_fifo
  import bf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic                   push,
  input  bf_byte_t               push_data,
  input  logic                   pop,
  output bf_byte_t               pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  bf_byte_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read combinationally so the consumer can load it on the same edge it pops.
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/bf_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes from the core queue in a FIFO and leave LSB first on tx.
module bf_uart_tx
  import bf_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        resetn,
  bf_uart_tx_if.slave                 in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("bf_uart_tx: CLK_HZ/BAUD must give at least 2 clocks per bit");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bf_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  bf_byte_t    fifo_head;

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] baud_reg, baud_next;
  logic [2:0]       bit_reg, bit_next;
  bf_byte_t         shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             baud_done;

  // Ready reflects registered occupancy only; a pop on the same edge does not open a slot early.
  assign in_if.in_ready = !fifo_full;
  assign fifo_push      = in_if.in_valid && !fifo_full;

  bf_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (in_if.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done = (baud_reg == BAUD_LAST);
  assign tx        = tx_reg;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    fifo_pop   = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
        end
      end

      START: begin
        if (baud_done) begin
          tx_next    = shift_reg[0];
          bit_next   = '0;
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
            bit_next   = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + CNT_W'(1);
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Directed bench for bf_uart_tx at 4 clocks per bit with a 4-entry FIFO.
module tb_bf_uart_tx;
  import bf_pkg::*;

  logic       CLK;
  logic       resetn;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks;
  int n_fail;

  logic [8:0] rx_q[$];

  bf_uart_tx_if in_if();

  bf_uart_tx #(
    .CLK_HZ     (1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .in_if      (in_if.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  // Line monitor: samples each bit mid-period, records {stop, byte}; frames hit by reset are dropped.
  initial begin
    logic [7:0] b;
    logic       stop;
    bit         aborted;
    forever begin
      @(negedge CLK);
      if (resetn === 1'b1 && tx === 1'b0) begin
        b = '0;
        aborted = 1'b0;
        repeat (2) begin @(negedge CLK); if (resetn !== 1'b1) aborted = 1'b1; end
        for (int j = 0; j < 8; j++) begin
          repeat (4) begin @(negedge CLK); if (resetn !== 1'b1) aborted = 1'b1; end
          b[j] = tx;
        end
        repeat (4) begin @(negedge CLK); if (resetn !== 1'b1) aborted = 1'b1; end
        stop = tx;
        if (!aborted) begin
          rx_q.push_back({stop, b});
          $display("line byte 0x%02h stop %b at %0t", b, stop, $time);
        end
      end
    end
  end

  task automatic wait_idle(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge CLK);
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data = 8'h00;
    repeat (3) @(negedge CLK);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_if.in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    resetn = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    rx_q.delete();
    @(negedge CLK);
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'hA5;
    @(negedge CLK);
    in_if.in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_accept: got %0d want 1", fifo_count); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_accept: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_accept: got %b want 1", busy); end
    @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_popped: got %0d want 0", fifo_count); end
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (tx !== frame_bit(8'hA5, i / 4)) begin
        n_fail++; $display("FAIL single_line[%0d]: got %b want %b", i, tx, frame_bit(8'hA5, i / 4));
      end
      @(negedge CLK);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_end: got %b want 1", tx); end
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 1a5", rx_q.size(), rx_q[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    rx_q.delete();
    @(negedge CLK);
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h48;
    @(negedge CLK);
    in_if.in_data = 8'h69;
    @(negedge CLK);
    in_if.in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", fifo_count); end
    for (int i = 0; i < 80; i++) begin
      b = (i < 40) ? 8'h48 : 8'h69;
      n_checks++;
      if (tx !== frame_bit(b, (i % 40) / 4)) begin
        n_fail++; $display("FAIL b2b_line[%0d]: got %b want %b", i, tx, frame_bit(b, (i % 40) / 4));
      end
      @(negedge CLK);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    n_checks++; if (rx_q.size() != 2 || rx_q[0] !== 9'h148 || rx_q[1] !== 9'h169) begin
      n_fail++; $display("FAIL b2b_rx: got %0d bytes %h %h want 148 169", rx_q.size(), rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_overflow;
    logic [2:0] exp_cnt [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    bit to;
    rx_q.delete();
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      n_checks++;
      if (fifo_count !== exp_cnt[k]) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d want %0d", k, fifo_count, exp_cnt[k]); end
      n_checks++;
      if (in_if.in_ready !== (k < 5)) begin n_fail++; $display("FAIL ovf_ready[%0d]: got %b want %b", k, in_if.in_ready, (k < 5)); end
      in_if.in_valid = 1'b1;
      in_if.in_data = 8'(k + 1);
    end
    @(negedge CLK);
    in_if.in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_final: got %0d want 4", fifo_count); end
    wait_idle(400, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL ovf_idle_timeout: got busy want idle"); end
    n_checks++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_rx_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx_q[i] !== {1'b1, 8'(i + 1)}) begin n_fail++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[i], {1'b1, 8'(i + 1)}); end
    end
  endtask

  task automatic test_full_push;
    logic [7:0] exp_b [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    bit to;
    rx_q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      in_if.in_valid = 1'b1;
      in_if.in_data = exp_b[k];
    end
    @(negedge CLK);
    in_if.in_data = 8'h66;
    repeat (36) @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count_before_pop: got %0d want 4", fifo_count); end
    n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_before_pop: got %b want 0", in_if.in_ready); end
    @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_count_after_pop: got %0d want 3", fifo_count); end
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", in_if.in_ready); end
    @(negedge CLK);
    in_if.in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count_refill: got %0d want 4", fifo_count); end
    n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_refill: got %b want 0", in_if.in_ready); end
    repeat (38) @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count_pre2: got %0d want 4", fifo_count); end
    @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_count_post2: got %0d want 3", fifo_count); end
    repeat (39) @(negedge CLK);
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_ready: got %b want 1", in_if.in_ready); end
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h77;
    @(negedge CLK);
    in_if.in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pushpop_count: got %0d want 3", fifo_count); end
    wait_idle(400, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_idle_timeout: got busy want idle"); end
    n_checks++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL full_rx_count: got %0d want 7", rx_q.size()); end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (rx_q[i] !== {1'b1, exp_b[i]}) begin n_fail++; $display("FAIL full_rx[%0d]: got %h want %h", i, rx_q[i], {1'b1, exp_b[i]}); end
    end
  endtask

  task automatic test_reset_midframe;
    rx_q.delete();
    @(negedge CLK); in_if.in_valid = 1'b1; in_if.in_data = 8'hFF;
    @(negedge CLK); in_if.in_data = 8'hAA;
    @(negedge CLK); in_if.in_data = 8'hBB;
    @(negedge CLK); in_if.in_valid = 1'b0;
    repeat (16) @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL rst_count_before: got %0d want 2", fifo_count); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx_async: got %b want 1", tx); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count_async: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_async: got %b want 0", busy); end
    @(negedge CLK);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_idle_line[%0d]: got %b want 1", i, tx); end
    end
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", in_if.in_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count_after: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rst_rx_dropped: got %0d bytes want 0", rx_q.size()); end
    // Second abort lands in the start bit, where the line is actively low.
    @(negedge CLK); in_if.in_valid = 1'b1; in_if.in_data = 8'h00;
    @(negedge CLK); in_if.in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_start_low: got %b want 0", tx); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_start_tx_async: got %b want 1", tx); end
    @(negedge CLK);
    resetn = 1'b1;
    repeat (45) @(negedge CLK);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_start_idle: got %b want 1", tx); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rst_start_rx_dropped: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_zero;
    logic exp_tx;
    rx_q.delete();
    @(negedge CLK); in_if.in_valid = 1'b1; in_if.in_data = 8'h00;
    @(negedge CLK); in_if.in_valid = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 44; i++) begin
      exp_tx = (i >= 36);
      n_checks++;
      if (tx !== exp_tx) begin n_fail++; $display("FAIL zero_line[%0d]: got %b want %b", i, tx, exp_tx); end
      @(negedge CLK);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 9'h100) begin
      n_fail++; $display("FAIL zero_rx: got %0d bytes first %h want 1 byte 100", rx_q.size(), rx_q[0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push();
    test_reset_midframe();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
